// File: rtl/aliquot_pkg.sv
// Shared definitions for the aliquot classifier: class encodings, FSM states
// and the aliquot-sum width helper.
package aliquot_pkg;

    // Class encodings reported on cls
    localparam logic [1:0] CLS_DEF  = 2'b00;   // S(N) <  N
    localparam logic [1:0] CLS_PERF = 2'b01;   // S(N) == N
    localparam logic [1:0] CLS_ABUN = 2'b10;   // S(N) >  N
    localparam logic [1:0] CLS_INV  = 2'b11;   // N == 0

    // Controller states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        DIV      = 3'd2,
        ACC      = 3'd3,
        FINISH   = 3'd4,
        WAIT_LOW = 3'd5
    } state_t;

    // Aliquot-sum width: S(N) < 8N, so three extra bits always suffice
    function automatic int sum_width(input int w);
        return w + 32'sd3;
    endfunction

endpackage

// File: rtl/aliquot_seq_remainder.sv
// Sequential restoring-remainder unit. One dividend bit is consumed per
// cycle, MSB first; the first bit is consumed on the edge that samples
// start, so valid pulses W cycles after the start cycle and rem then holds
// dividend % divisor until the next start.
module seq_remainder
    import aliquot_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         valid,
    output logic [W-1:0] rem
);

    localparam int CW = $clog2(W + 1);

    logic [W:0]    r_r;       // partial remainder, always < divisor after a step
    logic [W-1:0]  dvd_r;     // remaining dividend bits, next bit in the MSB
    logic [W-1:0]  dsr_r;     // latched divisor
    logic [CW-1:0] cnt_r;     // iterations still to perform
    logic          valid_r;

    // One restoring step: shift in a dividend bit, subtract divisor if it fits
    function automatic logic [W:0] restore_step(input logic [W:0]   r,
                                                input logic         b,
                                                input logic [W-1:0] d);
        logic [W:0] sh;
        sh = {r[W-1:0], b};
        if (sh >= {1'b0, d}) begin
            restore_step = sh - {1'b0, d};
        end else begin
            restore_step = sh;
        end
    endfunction

    // Iteration register: start restarts from a cleared remainder with the dividend MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r     <= {(W+1){1'b0}};
            dvd_r   <= {W{1'b0}};
            dsr_r   <= {W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            valid_r <= 1'b0;
        end else if (start) begin
            r_r     <= restore_step({(W+1){1'b0}}, dividend[W-1], divisor);
            dvd_r   <= {dividend[W-2:0], 1'b0};
            dsr_r   <= divisor;
            cnt_r   <= CW'(W - 1);
            valid_r <= 1'b0;
        end else if (cnt_r != {CW{1'b0}}) begin
            r_r     <= restore_step(r_r, dvd_r[W-1], dsr_r);
            dvd_r   <= {dvd_r[W-2:0], 1'b0};
            cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            valid_r <= (cnt_r == {{(CW-1){1'b0}}, 1'b1});
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign rem   = r_r[W-1:0];

endmodule

// File: rtl/aliquot_classifier.sv
// Aliquot-sum classifier: sums the proper divisors of N by trial division
// with k = 1 .. floor(N/2) and classifies N as deficient, perfect or
// abundant. Handshake is go (level) / busy / one-cycle done; a result is
// issued once per go assertion, and go must drop before the next run.
module aliquot_classifier
    import aliquot_pkg::*;
#(
    parameter int W  = 16,
    parameter int SW = sum_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [W-1:0]  n_in,
    output logic          busy,
    output logic          done,
    output logic [1:0]    cls,
    output logic [SW-1:0] sum
);

    state_t        state_r, state_nxt;
    logic [W-1:0]  n_r, n_nxt;        // captured operand
    logic [SW-1:0] s_r, s_nxt;        // running aliquot sum
    logic [W-1:0]  k_r, k_nxt;        // current trial divisor, peaks at 2^(W-1)
    logic          busy_r, busy_nxt;
    logic          done_r, done_nxt;
    logic [1:0]    cls_r, cls_nxt;
    logic [SW-1:0] sum_r, sum_nxt;

    logic          div_start_s;
    logic          div_valid_s;
    logic [W-1:0]  rem_s;

    seq_remainder #(.W(W)) u_rem (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (n_r),
        .divisor  (k_r),
        .valid    (div_valid_s),
        .rem      (rem_s)
    );

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state, datapath updates and next output values
    always_comb begin
        state_nxt   = state_r;
        n_nxt       = n_r;
        s_nxt       = s_r;
        k_nxt       = k_r;
        div_start_s = 1'b0;
        done_nxt    = 1'b0;
        cls_nxt     = cls_r;
        sum_nxt     = sum_r;

        case (state_r)
            IDLE: begin
                if (go) begin
                    n_nxt     = n_in;
                    s_nxt     = {SW{1'b0}};
                    k_nxt     = {{(W-1){1'b0}}, 1'b1};
                    state_nxt = CHECK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CHECK: begin
                // trials stop once k exceeds floor(N/2)
                if (k_r > {1'b0, n_r[W-1:1]}) begin
                    state_nxt = FINISH;
                end else begin
                    div_start_s = 1'b1;
                    state_nxt   = DIV;
                end
            end
            DIV: begin
                if (div_valid_s) begin
                    state_nxt = ACC;
                end else begin
                    state_nxt = DIV;
                end
            end
            ACC: begin
                if (rem_s == {W{1'b0}}) begin
                    s_nxt = s_r + {{(SW-W){1'b0}}, k_r};
                end else begin
                    s_nxt = s_r;
                end
                k_nxt     = k_r + {{(W-1){1'b0}}, 1'b1};
                state_nxt = CHECK;
            end
            FINISH: begin
                done_nxt = 1'b1;
                sum_nxt  = s_r;
                if (n_r == {W{1'b0}}) begin
                    cls_nxt = CLS_INV;
                end else if (s_r < {{(SW-W){1'b0}}, n_r}) begin
                    cls_nxt = CLS_DEF;
                end else if (s_r == {{(SW-W){1'b0}}, n_r}) begin
                    cls_nxt = CLS_PERF;
                end else begin
                    cls_nxt = CLS_ABUN;
                end
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!go) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_LOW;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == CHECK) || (state_nxt == DIV) ||
                   (state_nxt == ACC)   || (state_nxt == FINISH);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_r    <= {W{1'b0}};
            s_r    <= {SW{1'b0}};
            k_r    <= {W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cls_r  <= 2'b00;
            sum_r  <= {SW{1'b0}};
        end else begin
            n_r    <= n_nxt;
            s_r    <= s_nxt;
            k_r    <= k_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            cls_r  <= cls_nxt;
            sum_r  <= sum_nxt;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign cls  = cls_r;
    assign sum  = sum_r;

endmodule
